// File: rtl/multdiv_seq_unit.sv
// Iterative signed multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per clock, with flush, restart-on-start and optional early-out on zero operands.
module multdiv_seq_unit #(
  parameter int WIDTH     = 32,
  parameter int TAG_W     = 5,
  parameter int EARLY_OUT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             busy,
  output logic             data_resultRDY,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Mult: hi:lo is the running product, lo starts as the multiplier.
  // Div:  hi is the partial remainder, lo shifts dividend out and quotient in.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             neg_q, neg_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic [TAG_W-1:0] otag_q, otag_d;

  logic start_mult, start_div, start;
  logic iterating, is_mult, last, early;

  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     rsh;
  logic [WIDTH:0]     rdiff;
  logic               r_ge;
  logic [2*WIDTH-1:0] mag, prod;
  logic [WIDTH:0]     prod_top;
  logic               mult_exc;
  logic [WIDTH-1:0]   div_res;
  logic               div_exc;
  logic [WIDTH-1:0]   abs_a, abs_b;

  // A start needs exactly one of the two strobes.
  assign start_mult = ctrl_MULT & ~ctrl_DIV;
  assign start_div  = ctrl_DIV & ~ctrl_MULT;
  assign start      = start_mult | start_div;

  // Two's-complement magnitude; MIN maps onto 2^(WIDTH-1) as an unsigned value.
  assign abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  assign is_mult = (state_q == S_MULT);
  assign last    = iterating && (cnt_q == CNT_LAST);
  assign early   = (EARLY_OUT != 0) && iterating && (cnt_q == '0) &&
                   ((mcand_q == '0) || (is_mult && (lo_q == '0)));

  assign msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign rsh   = {hi_q, lo_q[WIDTH-1]};
  assign r_ge  = (rsh >= {1'b0, mcand_q});
  assign rdiff = rsh - {1'b0, mcand_q};

  // Signed product fits iff its top WIDTH+1 bits are all equal.
  assign mag      = {hi_q, lo_q};
  assign prod     = neg_q ? (~mag + 1'b1) : mag;
  assign prod_top = prod[2*WIDTH-1:WIDTH-1];
  assign mult_exc = ~((&prod_top) | (~|prod_top));

  // Unsigned quotient 2^(WIDTH-1) with a positive sign is only reachable by MIN / -1.
  always_comb begin
    div_res = neg_q ? (~lo_q + 1'b1) : lo_q;
    div_exc = ~neg_q & lo_q[WIDTH-1];
    if (mcand_q == '0) begin
      div_res = '0;
      div_exc = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d = start_mult ? S_MULT : S_DIV;
    end else begin
      case (state_q)
        S_MULT, S_DIV: if (last) state_d = S_DONE;
        S_DONE:        state_d = S_IDLE;
        default:       state_d = state_q;
      endcase
    end
  end

  always_comb begin
    iterating      = (state_q == S_MULT) || (state_q == S_DIV);
    busy           = iterating;
    data_resultRDY = (state_q == S_DONE);
  end

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    exc_d   = exc_q;
    otag_d  = otag_q;
    if (flush) begin
      cnt_d = '0;
    end else if (start) begin
      mcand_d = start_mult ? abs_a : abs_b;
      lo_d    = start_mult ? abs_b : abs_a;
      hi_d    = '0;
      neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      tag_d   = in_tag;
      cnt_d   = '0;
    end else if (iterating) begin
      if (last) begin
        res_d  = is_mult ? prod[WIDTH-1:0] : div_res;
        exc_d  = is_mult ? mult_exc : div_exc;
        otag_d = tag_q;
      end else if (early) begin
        // Zero product (or divide-by-zero, overridden at fix-up): skip to the final edge.
        cnt_d = CNT_LAST;
        hi_d  = '0;
        lo_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (is_mult) begin
          hi_d = msum[WIDTH:1];
          lo_d = {msum[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = r_ge ? rdiff[WIDTH-1:0] : rsh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], r_ge};
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      otag_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      otag_q  <= otag_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign out_tag        = otag_q;

endmodule

// File: tb/tb_multdiv_seq_unit.sv
// Bench for multdiv_seq_unit: transaction-level arithmetic model checked every cycle,
// directed literal cases, then randomized start/flush/restart traffic.
module tb_multdiv_seq_unit;

  logic        clock, reset;
  logic        ctrl_MULT, ctrl_DIV, flush;
  logic [31:0] data_operandA, data_operandB;
  logic [4:0]  in_tag;
  logic        busy, data_resultRDY, data_exception;
  logic [31:0] data_result;
  logic [4:0]  out_tag;
  logic        busy0, rdy0, exc0;
  logic [31:0] res0;
  logic [4:0]  tag0;

  int checks = 0;
  int failures = 0;

  multdiv_seq_unit #(.WIDTH(32), .TAG_W(5), .EARLY_OUT(1)) u_dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB), .in_tag(in_tag),
    .flush(flush), .busy(busy), .data_resultRDY(data_resultRDY),
    .data_result(data_result), .data_exception(data_exception), .out_tag(out_tag));

  multdiv_seq_unit #(.WIDTH(32), .TAG_W(5), .EARLY_OUT(0)) u_dut0 (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB), .in_tag(in_tag),
    .flush(flush), .busy(busy0), .data_resultRDY(rdy0),
    .data_result(res0), .data_exception(exc0), .out_tag(tag0));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the signed definitions.
  function automatic void model_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output bit e, output int lat);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (mul) begin
      p   = sa * sb;
      r   = p[31:0];
      e   = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      lat = (sa == 0 || sb == 0) ? 2 : 33;
    end else if (sb == 0) begin
      r = 32'h0; e = 1'b1; lat = 2;
    end else if (sa == -64'sd2147483648 && sb == -1) begin
      r = 32'h8000_0000; e = 1'b1; lat = 33;
    end else begin
      p = sa / sb;
      r = p[31:0]; e = 1'b0; lat = 33;
    end
  endfunction

  // Transaction model: an op in flight counts down edges until its result lands.
  bit          m_pend = 0, m_rdy = 0, m_exc = 0, p_exc = 0;
  int          m_rem = 0;
  logic [31:0] m_res = '0, p_res = '0;
  logic [4:0]  m_tag = '0, p_tag = '0;

  always @(posedge clock or posedge reset) begin
    int lat;
    bit st_m, st_d;
    if (reset) begin
      m_pend = 0; m_rdy = 0; m_rem = 0; m_res = '0; m_exc = 0; m_tag = '0;
    end else begin
      st_m  = ctrl_MULT && !ctrl_DIV;
      st_d  = ctrl_DIV && !ctrl_MULT;
      m_rdy = 0;
      if (flush) begin
        m_pend = 0;
      end else if (st_m || st_d) begin
        model_op(st_m, data_operandA, data_operandB, p_res, p_exc, lat);
        p_tag  = in_tag;
        m_pend = 1;
        m_rem  = lat;
      end else if (m_pend) begin
        m_rem--;
        if (m_rem == 0) begin
          m_pend = 0; m_rdy = 1; m_res = p_res; m_exc = p_exc; m_tag = p_tag;
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("cyc_busy", busy, m_pend);
    chk("cyc_rdy", data_resultRDY, m_rdy);
    chk("cyc_result", data_result, m_res);
    chk("cyc_exc", data_exception, m_exc);
    chk("cyc_tag", out_tag, m_tag);
  end

  // Edge counter and RDY monitor used by the directed cases.
  int          edge_no = 0;
  int          rdy_cnt = 0, rdy_edge = 0, rdy_cnt0 = 0, rdy_edge0 = 0;
  logic [31:0] rdy_res = '0, rdy_res0 = '0;
  logic        rdy_exc = 0, rdy_exc0 = 0;
  logic [4:0]  rdy_tag = '0;

  always @(posedge clock) edge_no++;

  always @(negedge clock) begin
    if (data_resultRDY) begin
      rdy_cnt++; rdy_edge = edge_no;
      rdy_res = data_result; rdy_exc = data_exception; rdy_tag = out_tag;
    end
    if (rdy0) begin
      rdy_cnt0++; rdy_edge0 = edge_no; rdy_res0 = res0; rdy_exc0 = exc0;
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clr_ctrl();
    ctrl_MULT = 0; ctrl_DIV = 0; flush = 0;
  endtask

  task automatic run_dir(input string nm, input bit mul, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tg, input int lat,
                         input logic [31:0] eres, input logic eexc);
    int c0, c00, e0;
    c0 = rdy_cnt; c00 = rdy_cnt0;
    ctrl_MULT = mul; ctrl_DIV = !mul;
    data_operandA = a; data_operandB = b; in_tag = tg;
    step();
    e0 = edge_no;
    clr_ctrl();
    repeat (40) step();
    chk({nm, "_rdy_count"}, rdy_cnt - c0, 1);
    chk({nm, "_latency"}, rdy_edge - e0, lat);
    chk({nm, "_result"}, rdy_res, eres);
    chk({nm, "_exc"}, rdy_exc, eexc);
    chk({nm, "_tag"}, rdy_tag, tg);
    chk({nm, "_fixed_rdy_count"}, rdy_cnt0 - c00, 1);
    chk({nm, "_fixed_latency"}, rdy_edge0 - e0, 33);
    chk({nm, "_fixed_result"}, rdy_res0, eres);
    chk({nm, "_fixed_exc"}, rdy_exc0, eexc);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h1;
      4: v = 32'($urandom_range(0, 40)) - 32'd20;
      5: v = 32'($urandom_range(0, 65535));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int c0, e0;
    reset = 1; clr_ctrl();
    data_operandA = '0; data_operandB = '0; in_tag = '0;
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_rdy", data_resultRDY, 0);
    chk("reset_result", data_result, 0);
    chk("reset_tag", out_tag, 0);
    reset = 0;
    step();

    run_dir("mul_neg7x6",  1, 32'hFFFF_FFF9, 32'd6, 5'd3,  33, 32'hFFFF_FFD6, 1'b0);
    run_dir("mul_ovf",     1, 32'h7FFF_FFFF, 32'd2, 5'd9,  33, 32'hFFFF_FFFE, 1'b1);
    run_dir("mul_zero",    1, 32'h0,         32'd5, 5'd4,  2,  32'h0,         1'b0);
    run_dir("div_neg7by2", 0, 32'hFFFF_FFF9, 32'd2, 5'd11, 33, 32'hFFFF_FFFD, 1'b0);
    run_dir("div_min_m1",  0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 33, 32'h8000_0000, 1'b1);
    run_dir("div_by_zero", 0, 32'd5, 32'h0, 5'd31, 2, 32'h0, 1'b1);

    // Flush at E10 squashes the op; a new op at E12 completes at E45.
    c0 = rdy_cnt;
    ctrl_MULT = 1; data_operandA = 32'd5; data_operandB = 32'd9; in_tag = 5'd1;
    step(); e0 = edge_no; clr_ctrl();
    while (edge_no < e0 + 9) step();
    flush = 1;
    step(); flush = 0;
    chk("flush_busy_low", busy, 0);
    step();
    ctrl_MULT = 1; data_operandA = 32'd3; data_operandB = 32'd4; in_tag = 5'd2;
    step(); clr_ctrl();
    repeat (40) step();
    chk("flush_rdy_count", rdy_cnt - c0, 1);
    chk("flush_new_latency", rdy_edge - e0, 45);
    chk("flush_new_result", rdy_res, 32'd12);

    // Restart: DIV at E0 replaced by MULT 2*3 at E5, single RDY after E38.
    c0 = rdy_cnt;
    ctrl_DIV = 1; data_operandA = 32'd100; data_operandB = 32'd7; in_tag = 5'd5;
    step(); e0 = edge_no; clr_ctrl();
    while (edge_no < e0 + 4) step();
    ctrl_MULT = 1; data_operandA = 32'd2; data_operandB = 32'd3; in_tag = 5'd6;
    step(); clr_ctrl();
    repeat (40) step();
    chk("restart_rdy_count", rdy_cnt - c0, 1);
    chk("restart_latency", rdy_edge - e0, 38);
    chk("restart_result", rdy_res, 32'd6);
    chk("restart_tag", rdy_tag, 5'd6);

    // Reset mid-operation clears held outputs at once and the op never completes.
    ctrl_MULT = 1; data_operandA = 32'hFFFF_FFFD; data_operandB = 32'hFFFF_FFFD; in_tag = 5'd7;
    step(); clr_ctrl();
    repeat (5) step();
    reset = 1;
    #1;
    chk("rst_mid_result", data_result, 0);
    chk("rst_mid_tag", out_tag, 0);
    chk("rst_mid_busy", busy, 0);
    step(); reset = 0;
    c0 = rdy_cnt;
    repeat (40) step();
    chk("rst_mid_no_rdy", rdy_cnt - c0, 0);

    // Random traffic: sparse starts while busy so many ops complete, some restarts/flushes.
    repeat (4000) begin
      int r;
      clr_ctrl();
      r = $urandom_range(0, 99);
      if (m_pend ? (r < 1) : (r < 12)) ctrl_MULT = 1;
      else if (m_pend ? (r < 2) : (r < 24)) ctrl_DIV = 1;
      else if (r == 50) begin ctrl_MULT = 1; ctrl_DIV = 1; end
      if ($urandom_range(0, 79) == 0) flush = 1;
      data_operandA = rnd_op();
      data_operandB = rnd_op();
      in_tag = 5'($urandom_range(0, 31));
      step();
    end
    clr_ctrl();
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
